// File: rtl/simon_mode_engine.sv
// Mode-of-operation wrapper (ECB/CBC/CTR/OFB) around an external iterative Simon core.
// One block is in flight at a time; chaining value, counter or OFB state lives in fb_q.
module simon_mode_engine #(
    parameter int unsigned WW       = 16,
    parameter int unsigned NKW      = 4,
    parameter logic        DATA_RST = 1'b0
) (
    input  logic                clk,
    input  logic                srst,
    output logic                busy_o,

    input  logic                msg_valid_i,
    output logic                msg_ready_o,
    input  logic [1:0]          msg_mode_i,
    input  logic                msg_dir_i,
    input  logic [NKW*WW-1:0]   msg_key_i,
    input  logic [2*WW-1:0]     msg_iv_i,

    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [2*WW-1:0]     in_data_i,
    input  logic                in_last_i,

    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [2*WW-1:0]     out_data_o,
    output logic                out_last_o,

    output logic                cph_valid_o,
    input  logic                cph_ready_i,
    output logic                cph_mode_o,
    output logic [2*WW-1:0]     cph_pt_o,
    output logic [NKW*WW-1:0]   cph_key_o,
    input  logic                cph_valid_i,
    output logic                cph_ready_o,
    input  logic [2*WW-1:0]     cph_ct_i
);

    localparam int unsigned BW = 2 * WW;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_IN, S_CPH_REQ, S_CPH_RSP, S_OUT
    } state_e;

    typedef enum logic [1:0] {
        M_ECB = 2'b00, M_CBC = 2'b01, M_CTR = 2'b10, M_OFB = 2'b11
    } mode_e;

    state_e              state_q, state_d;
    mode_e               mode_q;
    logic                dir_q;
    logic                last_q;
    logic [NKW*WW-1:0]   key_q;
    logic [BW-1:0]       fb_q, fb_d;
    logic [BW-1:0]       din_q;
    logic [BW-1:0]       out_q, out_d;

    logic msg_hs, in_hs, cph_rsp_hs;

    // Handshake outputs come straight from the state register, never from inputs.
    assign msg_ready_o = (state_q == S_IDLE);
    assign in_ready_o  = (state_q == S_WAIT_IN);
    assign cph_valid_o = (state_q == S_CPH_REQ);
    assign cph_ready_o = (state_q == S_CPH_RSP);
    assign out_valid_o = (state_q == S_OUT);
    assign busy_o      = (state_q != S_IDLE);

    assign msg_hs     = msg_ready_o & msg_valid_i;
    assign in_hs      = in_ready_o  & in_valid_i;
    assign cph_rsp_hs = cph_ready_o & cph_valid_i;

    assign out_data_o = out_q;
    assign out_last_o = last_q;
    assign cph_key_o  = key_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (msg_valid_i) state_d = S_WAIT_IN;
            S_WAIT_IN: if (in_valid_i)  state_d = S_CPH_REQ;
            S_CPH_REQ: if (cph_ready_i) state_d = S_CPH_RSP;
            S_CPH_RSP: if (cph_valid_i) state_d = S_OUT;
            S_OUT:     if (out_ready_i) state_d = last_q ? S_IDLE : S_WAIT_IN;
            default:                    state_d = S_IDLE;
        endcase
    end

    always_comb begin : mode_datapath
        cph_pt_o   = din_q;
        cph_mode_o = 1'b0;
        out_d      = cph_ct_i;
        fb_d       = fb_q;
        case (mode_q)
            M_ECB: cph_mode_o = dir_q;
            M_CBC: begin
                if (dir_q) begin
                    cph_mode_o = 1'b1;
                    out_d      = cph_ct_i ^ fb_q;
                    fb_d       = din_q;
                end else begin
                    cph_pt_o   = din_q ^ fb_q;
                    fb_d       = cph_ct_i;
                end
            end
            // Counter wraps silently modulo 2^BW.
            M_CTR: begin
                cph_pt_o = fb_q;
                out_d    = din_q ^ cph_ct_i;
                fb_d     = fb_q + BW'(1);
            end
            M_OFB: begin
                cph_pt_o = fb_q;
                out_d    = din_q ^ cph_ct_i;
                fb_d     = cph_ct_i;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin : ctrl_regs
        if (srst) begin
            state_q <= S_IDLE;
            mode_q  <= M_ECB;
            dir_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (msg_hs) begin
                mode_q <= mode_e'(msg_mode_i);
                dir_q  <= msg_dir_i;
            end
            if (in_hs) last_q <= in_last_i;
        end
    end

    // NOTE: wide data registers are cleared by srst only when DATA_RST is set; control is always reset.
    always_ff @(posedge clk) begin : data_regs
        if (srst && DATA_RST) begin
            key_q <= '0;
            fb_q  <= '0;
            din_q <= '0;
            out_q <= '0;
        end else if (!srst) begin
            if (msg_hs) begin
                key_q <= msg_key_i;
                fb_q  <= msg_iv_i;
            end
            if (in_hs) din_q <= in_data_i;
            if (cph_rsp_hs) begin
                out_q <= out_d;
                fb_q  <= fb_d;
            end
        end
    end

endmodule

// File: tb/tb_simon_mode_engine.sv
// Bench for simon_mode_engine (Simon32/64): a Simon reference model acts as the cipher core,
// a message-level mode model fills expectation queues, and a negedge process compares each cycle.
`timescale 1ns/1ps
module tb_simon_mode_engine;

    localparam int WW = 16, NKW = 4, BW = 32, KW = 64;
    localparam int CPH_LAT = 2;
    localparam logic [63:0] KEY = 64'h1918_1110_0908_0100;

    logic clk = 1'b0;
    logic srst;
    logic busy_o, msg_valid_i, msg_ready_o, msg_dir_i;
    logic [1:0] msg_mode_i;
    logic [KW-1:0] msg_key_i, cph_key_o;
    logic [BW-1:0] msg_iv_i, in_data_i, out_data_o, cph_pt_o, cph_ct_i;
    logic in_valid_i, in_ready_o, in_last_i;
    logic out_valid_o, out_ready_i, out_last_o;
    logic cph_valid_o, cph_ready_i, cph_mode_o, cph_valid_i, cph_ready_o;

    always #5 clk = ~clk;

    simon_mode_engine #(.WW(WW), .NKW(NKW), .DATA_RST(1'b1)) dut (
        .clk(clk), .srst(srst), .busy_o(busy_o),
        .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o), .msg_mode_i(msg_mode_i),
        .msg_dir_i(msg_dir_i), .msg_key_i(msg_key_i), .msg_iv_i(msg_iv_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_last_i(in_last_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_last_o(out_last_o),
        .cph_valid_o(cph_valid_o), .cph_ready_i(cph_ready_i), .cph_mode_o(cph_mode_o),
        .cph_pt_o(cph_pt_o), .cph_key_o(cph_key_o),
        .cph_valid_i(cph_valid_i), .cph_ready_o(cph_ready_o), .cph_ct_i(cph_ct_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- Simon32/64 reference ----------------
    function automatic logic [15:0] rol(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] sf(input logic [15:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    function automatic logic [31:0] simon(input logic [31:0] blk, input logic dec, input logic [63:0] key);
        logic [15:0] k [32];
        logic [61:0] z;
        logic [15:0] x, y, t;
        z = {2{31'b1111101000100101011000011100110}};
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = rol(k[i-1], 13) ^ k[i-3];
            t = t ^ rol(t, 15);
            k[i] = ~k[i-4] ^ t ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
        end
        x = blk[31:16];
        y = blk[15:0];
        if (!dec) begin
            for (int i = 0; i < 32; i++) begin
                t = x; x = y ^ sf(x) ^ k[i]; y = t;
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                t = y; y = x ^ sf(y) ^ k[i]; x = t;
            end
        end
        return {x, y};
    endfunction

    // ---------------- expectations and observations ----------------
    typedef struct packed { logic [31:0] pt; logic md; logic [63:0] key; } cph_exp_t;
    typedef struct packed { logic [31:0] data; logic last; } out_exp_t;

    cph_exp_t    exp_cph[$];
    out_exp_t    exp_out[$];
    logic [31:0] blks[$];
    logic [31:0] got_pt[$], got_out[$];
    logic        got_md[$], got_last[$];
    int          got_out_wait[$], got_cph_wait[$];

    task automatic clear_got();
        got_pt.delete(); got_out.delete(); got_md.delete(); got_last.delete();
        got_out_wait.delete(); got_cph_wait.delete();
    endtask

    // Mode rules applied to a whole message, using the reference cipher.
    task automatic model_msg(input logic [1:0] mode, input logic dir, input logic [63:0] key, input logic [31:0] iv);
        logic [31:0] fb, din, pt, x, res;
        logic md;
        cph_exp_t ce;
        out_exp_t oe;
        fb = iv;
        foreach (blks[i]) begin
            din = blks[i];
            md  = 1'b0;
            if (mode == 2'b00) begin pt = din; md = dir; end
            else if (mode == 2'b01) begin pt = dir ? din : (din ^ fb); md = dir; end
            else pt = fb;
            x = simon(pt, md, key);
            case (mode)
                2'b00: res = x;
                2'b01: if (dir) begin res = x ^ fb; fb = din; end
                       else begin res = x; fb = x; end
                2'b10: begin res = din ^ x; fb = fb + 32'd1; end
                default: begin res = din ^ x; fb = x; end
            endcase
            ce.pt = pt; ce.md = md; ce.key = key;
            oe.data = res; oe.last = (i == blks.size() - 1);
            exp_cph.push_back(ce);
            exp_out.push_back(oe);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    int cph_wait = 0, out_wait = 0, hot;
    always @(negedge clk) begin
        if (!srst) begin
            hot = int'(msg_ready_o) + int'(in_ready_o) + int'(cph_valid_o) + int'(cph_ready_o) + int'(out_valid_o);
            check("state_onehot", 64'(hot), 64'd1);
            check("busy", 64'(busy_o), 64'(!msg_ready_o));
            if (cph_valid_o) begin
                if (exp_cph.size() == 0) check("cph_unexpected_req", 64'(exp_cph.size()), 64'd1);
                else begin
                    check("cph_pt", 64'(cph_pt_o), 64'(exp_cph[0].pt));
                    check("cph_mode", 64'(cph_mode_o), 64'(exp_cph[0].md));
                    check("cph_key", cph_key_o, exp_cph[0].key);
                    if (cph_ready_i) begin
                        got_pt.push_back(cph_pt_o); got_md.push_back(cph_mode_o);
                        got_cph_wait.push_back(cph_wait); cph_wait = 0;
                        void'(exp_cph.pop_front());
                    end else cph_wait++;
                end
            end
            if (out_valid_o) begin
                if (exp_out.size() == 0) check("out_unexpected", 64'(exp_out.size()), 64'd1);
                else begin
                    check("out_data", 64'(out_data_o), 64'(exp_out[0].data));
                    check("out_last", 64'(out_last_o), 64'(exp_out[0].last));
                    if (out_ready_i) begin
                        got_out.push_back(out_data_o); got_last.push_back(out_last_o);
                        got_out_wait.push_back(out_wait); out_wait = 0;
                        void'(exp_out.pop_front());
                    end else out_wait++;
                end
            end
        end else begin
            cph_wait = 0;
            out_wait = 0;
        end
    end

    // ---------------- cipher core model ----------------
    int          req_hold = 1, lat_cnt = 0;
    bit          pending = 0, c_rst, c_rq, c_rs, c_sv;
    logic [31:0] c_pt, c_res;
    logic        c_md;
    logic [63:0] c_key;
    initial begin
        cph_ready_i = 1'b0; cph_valid_i = 1'b0; cph_ct_i = '0;
        forever begin
            @(negedge clk);
            c_rst = srst; c_sv = cph_valid_o;
            c_rq = cph_valid_o & cph_ready_i; c_rs = cph_ready_o & cph_valid_i;
            c_pt = cph_pt_o; c_md = cph_mode_o; c_key = cph_key_o;
            @(posedge clk); #1;
            if (c_rst) begin
                pending = 0; cph_valid_i = 1'b0; cph_ready_i = 1'b0;
            end else if (c_rq) begin
                pending = 1; cph_ready_i = 1'b0; lat_cnt = CPH_LAT;
                c_res = simon(c_pt, c_md, c_key);
            end else if (c_rs) begin
                pending = 0; cph_valid_i = 1'b0; cph_ct_i = '0;
            end else if (pending) begin
                if (lat_cnt > 1) lat_cnt--;
                else begin cph_valid_i = 1'b1; cph_ct_i = c_res; end
            end else if (c_sv) begin
                if (req_hold > 1) req_hold--;
                else begin cph_ready_i = 1'b1; req_hold = 1; end
            end
        end
    end

    // ---------------- output sink ----------------
    int out_hold = 1;
    bit s_rst, s_hs, s_sv;
    initial begin
        out_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            s_rst = srst; s_sv = out_valid_o; s_hs = out_valid_o & out_ready_i;
            @(posedge clk); #1;
            if (s_rst || s_hs) out_ready_i = 1'b0;
            else if (s_sv && !out_ready_i) begin
                if (out_hold > 1) out_hold--;
                else begin out_ready_i = 1'b1; out_hold = 1; end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive_msg(input logic [1:0] mode, input logic dir, input logic [63:0] key, input logic [31:0] iv);
        bit hs = 0;
        msg_valid_i = 1'b1; msg_mode_i = mode; msg_dir_i = dir; msg_key_i = key; msg_iv_i = iv;
        for (int c = 0; c < 100 && !hs; c++) begin
            @(negedge clk); hs = msg_ready_o;
            tick();
        end
        check("msg_accept", 64'(hs), 64'd1);
        // Scramble msg_* so any late sampling shows up as a wrong key/IV.
        msg_valid_i = 1'b0; msg_mode_i = ~mode; msg_dir_i = ~dir;
        msg_key_i = ~key; msg_iv_i = $urandom;
    endtask

    task automatic drive_in(input logic [31:0] d, input logic last);
        bit hs = 0;
        in_valid_i = 1'b1; in_data_i = d; in_last_i = last;
        for (int c = 0; c < 200 && !hs; c++) begin
            @(negedge clk); hs = in_ready_o;
            tick();
        end
        check("in_accept", 64'(hs), 64'd1);
        in_valid_i = 1'b0; in_data_i = $urandom; in_last_i = 1'b0;
    endtask

    task automatic run_msg(input logic [1:0] mode, input logic dir, input logic [63:0] key, input logic [31:0] iv);
        int n = blks.size();
        clear_got();
        model_msg(mode, dir, key, iv);
        drive_msg(mode, dir, key, iv);
        for (int i = 0; i < n; i++) drive_in(blks[i], i == n - 1);
        for (int c = 0; c < 300 && got_out.size() < n; c++) tick();
        check("out_count", 64'(got_out.size()), 64'(n));
        check("exp_out_drained", 64'(exp_out.size()), 64'd0);
        check("exp_cph_drained", 64'(exp_cph.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit found;
        srst = 1'b1;
        msg_valid_i = 1'b0; msg_mode_i = '0; msg_dir_i = 1'b0; msg_key_i = '0; msg_iv_i = '0;
        in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0;
        repeat (3) tick();
        srst = 1'b0;
        @(negedge clk);
        check("rst_msg_ready", 64'(msg_ready_o), 64'd1);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd0);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_cph_valid", 64'(cph_valid_o), 64'd0);
        check("rst_cph_ready", 64'(cph_ready_o), 64'd0);
        check("rst_out_last", 64'(out_last_o), 64'd0);
        check("rst_out_data", 64'(out_data_o), 64'd0);
        check("rst_cph_pt", 64'(cph_pt_o), 64'd0);
        check("rst_cph_key", cph_key_o, 64'd0);
        tick();

        // ECB encrypt, single block
        blks = '{32'h6565_6877};
        run_msg(2'b00, 1'b0, KEY, 32'h0);
        check("ecb_enc_pt", 64'(got_pt[0]), 64'h6565_6877);
        check("ecb_enc_mode", 64'(got_md[0]), 64'd0);
        check("ecb_enc_out", 64'(got_out[0]), 64'hc69b_e9bb);
        check("ecb_enc_last", 64'(got_last[0]), 64'd1);
        @(negedge clk);
        check("ecb_back_idle", 64'(msg_ready_o), 64'd1);
        tick();

        // ECB decrypt
        blks = '{32'hc69b_e9bb};
        run_msg(2'b00, 1'b1, KEY, 32'h0);
        check("ecb_dec_mode", 64'(got_md[0]), 64'd1);
        check("ecb_dec_out", 64'(got_out[0]), 64'h6565_6877);

        // CBC encrypt, IV zero
        blks = '{32'h6565_6877, 32'ha3fe_81cc};
        run_msg(2'b01, 1'b0, KEY, 32'h0);
        check("cbc_enc_pt0", 64'(got_pt[0]), 64'h6565_6877);
        check("cbc_enc_pt1", 64'(got_pt[1]), 64'h6565_6877);
        check("cbc_enc_out0", 64'(got_out[0]), 64'hc69b_e9bb);
        check("cbc_enc_out1", 64'(got_out[1]), 64'hc69b_e9bb);

        // CBC decrypt restores the plaintexts
        blks = '{32'hc69b_e9bb, 32'hc69b_e9bb};
        run_msg(2'b01, 1'b1, KEY, 32'h0);
        check("cbc_dec_out0", 64'(got_out[0]), 64'h6565_6877);
        check("cbc_dec_out1", 64'(got_out[1]), 64'ha3fe_81cc);

        // CTR with counter wrap
        blks = '{32'h1234_5678, 32'h9abc_def0, 32'h0f0f_f0f0};
        run_msg(2'b10, 1'b1, KEY, 32'hffff_ffff);
        check("ctr_pt0", 64'(got_pt[0]), 64'hffff_ffff);
        check("ctr_pt1", 64'(got_pt[1]), 64'h0000_0000);
        check("ctr_pt2", 64'(got_pt[2]), 64'h0000_0001);
        check("ctr_mode2", 64'(got_md[2]), 64'd0);

        // OFB
        blks = '{32'hdead_beef, 32'h0bad_cafe};
        run_msg(2'b11, 1'b0, KEY, 32'h0123_4567);

        // Backpressure on the first block
        out_hold = 5;
        req_hold = 3;
        blks = '{32'h0102_0304, 32'h0506_0708};
        run_msg(2'b01, 1'b0, KEY, 32'h5555_aaaa);
        check("bp_out_wait", 64'(got_out_wait[0]), 64'd5);
        check("bp_cph_wait", 64'(got_cph_wait[0]), 64'd3);
        check("bp_cph_wait_nostall", 64'(got_cph_wait[1]), 64'd1);

        // Reset while block 2 waits for the cipher response
        clear_got();
        blks = '{32'h6565_6877, 32'ha3fe_81cc, 32'h1111_2222};
        model_msg(2'b01, 1'b0, KEY, 32'h0);
        drive_msg(2'b01, 1'b0, KEY, 32'h0);
        drive_in(blks[0], 1'b0);
        drive_in(blks[1], 1'b0);
        found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk); found = cph_ready_o;
            tick();
        end
        check("midrst_reached_rsp", 64'(found), 64'd1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        @(negedge clk);
        check("midrst_msg_ready", 64'(msg_ready_o), 64'd1);
        check("midrst_in_ready", 64'(in_ready_o), 64'd0);
        check("midrst_out_valid", 64'(out_valid_o), 64'd0);
        check("midrst_cph_valid", 64'(cph_valid_o), 64'd0);
        check("midrst_cph_ready", 64'(cph_ready_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_outs_seen", 64'(got_out.size()), 64'd1);
        tick();
        exp_cph.delete();
        exp_out.delete();

        // Fresh ECB message after the reset
        blks = '{32'h6565_6877};
        run_msg(2'b00, 1'b0, KEY, 32'h0);
        check("post_rst_ecb_out", 64'(got_out[0]), 64'hc69b_e9bb);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_mode_engine.md
Name: simon_mode_engine

Overview:
- Block-cipher mode-of-operation engine for the Simon family: ECB, CBC, CTR and OFB over multi-block messages.
- Sits between a streaming data interface and one iterative Simon cipher instance, reached through the cph_* valid/ready ports and instantiated alongside by the integrator.
- Per message, latches direction, mode, key and IV, then processes blocks one at a time. Feedback (chaining value, counter or OFB state) is handled internally.
- Parametrised in word size and key-word count so that any Simon configuration plugs in unchanged.

Parameters:
- WW, 16, word size n; legal values 16/24/32/48/64; block width = 2*WW.
- NKW, 4, key words m; legal (WW,NKW) pairs follow the Simon configuration table.
- DATA_RST, 1'b0, 1 = data registers (key, chain, in/out buffers) also cleared by srst; 0 = only control state is reset.

Ports:
- clk  in  1  clock, posedge
- srst  in  1  synchronous reset, active high
- busy_o  out  1  high whenever state != IDLE
- msg_valid_i  in  1  new-message request
- msg_ready_o  out  1  message accepted when msg_valid_i & msg_ready_o
- msg_mode_i  in  2  00 ECB, 01 CBC, 10 CTR, 11 OFB
- msg_dir_i  in  1  0 encrypt / 1 decrypt
- msg_key_i  in  NKW*WW  key, packed [NKW-1:0][WW-1:0]
- msg_iv_i  in  2*WW  IV or initial counter, packed [1:0][WW-1:0]
- in_valid_i, in_ready_o  in/out  1  data-block handshake
- in_data_i  in  2*WW  input block
- in_last_i  in  1  marks final block of the message
- out_valid_o, out_ready_i  out/in  1  result handshake
- out_data_o  out  2*WW  result block
- out_last_o  out  1  copy of in_last_i for this block
- cph_valid_o, cph_ready_i  out/in  1  request to cipher
- cph_mode_o  out  1  0 encrypt / 1 decrypt, to cipher
- cph_pt_o  out  2*WW  cipher input block
- cph_key_o  out  NKW*WW  latched key
- cph_valid_i, cph_ready_o  in/out  1  cipher response handshake
- cph_ct_i  in  2*WW  cipher output block

Behaviour:
- Reset (srst high at posedge): state = IDLE.
  - Output values after reset: msg_ready_o = 1; busy_o, in_ready_o, out_valid_o, cph_valid_o, cph_ready_o, out_last_o = 0.
  - out_data_o, cph_pt_o, cph_key_o = 0 if DATA_RST, else undefined.
  - srst wins over every simultaneous handshake.
- State machine. All handshake outputs are decoded from the registered state only; no combinational path from inputs to outputs.
  - IDLE: msg_ready_o = 1. On msg handshake, latch mode, dir, key and fb <= msg_iv_i, then go to WAIT_IN.
  - WAIT_IN: in_ready_o = 1. On handshake, latch din <= in_data_i and last <= in_last_i, then go to CPH_REQ.
  - CPH_REQ: cph_valid_o = 1; cph_pt_o and cph_mode_o are held stable. On cph_ready_i, go to CPH_RSP.
  - CPH_RSP: cph_ready_o = 1. On cph_valid_i, compute the result into the out register, update fb, then go to OUT.
  - OUT: out_valid_o = 1; out_data_o and out_last_o are held stable. On out_ready_i, go to IDLE if last, else WAIT_IN.
- Per-mode datapath (X = cph_ct_i):
  - ECB: cph_pt = din; cph_mode = dir; out = X; fb unused.
  - CBC enc: cph_pt = din ^ fb; cph_mode = 0; out = X; fb <= X.
  - CBC dec: cph_pt = din; cph_mode = 1; out = X ^ fb; fb <= din.
  - CTR (both dirs): cph_pt = fb; cph_mode = 0; out = din ^ X; fb <= fb + 1 modulo 2^(2*WW). Wraps all-ones to zero with no flag.
  - OFB (both dirs): cph_pt = fb; cph_mode = 0; out = din ^ X; fb <= X.
- Latency: one block every 4 + cipher-latency cycles minimum. No overlap between blocks, so at most one request is in flight.
- Backpressure: any number of stall cycles is allowed in each state; all held outputs stay stable. Upstream must keep in_* stable while in_valid_i & ~in_ready_o.
- Single-block message: in_last_i = 1 on the first block; the engine returns to IDLE after one OUT.
- Mid-operation reset: the in-flight block is discarded, and fb and counter are lost. The integrator must reset the cipher in the same cycle. The engine never absorbs a stale cph_valid_i outside CPH_RSP.
- msg_* inputs are ignored outside IDLE. in_valid_i is ignored outside WAIT_IN.

Test Plan:
- Simon32/64 ECB encrypt; key {1918,1110,0908,0100}, in 65656877, last=1 -> cph_pt_o = 65656877, cph_mode_o = 0, out_data_o = c69be9bb, out_last_o = 1, msg_ready_o = 1 after the OUT handshake.
- ECB decrypt, same key, in c69be9bb -> cph_mode_o = 1, out_data_o = 65656877.
- CBC encrypt, IV 00000000, blocks 65656877 then a3fe81cc -> cph_pt_o = 65656877 both times; out c69be9bb, c69be9bb. CBC decrypt of those two outputs restores both plaintexts.
- CTR, IV ffffffff, three blocks -> cph_pt_o = ffffffff, 00000000, 00000001 (wrap); cph_mode_o = 0; out = din ^ cph_ct_i for each block.
- Backpressure: hold out_ready_i = 0 for 5 cycles and cph_ready_i = 0 for 3 cycles -> out_data_o and cph_pt_o stable, in_ready_o = 0 throughout, no block lost or duplicated.
- srst asserted in CPH_RSP of block 2 -> next cycle msg_ready_o = 1 and all valids = 0. A new ECB message then produces c69be9bb.
